// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption sequencing controller.
package aes_ctrl_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;

  typedef enum logic [2:0] {
    SEL_ARK = 3'b000,
    SEL_ISR = 3'b001,
    SEL_IMC = 3'b010,
    SEL_ISB = 3'b011,
    SEL_MSG = 3'b100
  } msg_sel_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KEY_WAIT,
    ST_ARK0,
    ST_ISR,
    ST_ISB_WAIT,
    ST_ISB,
    ST_ARK,
    ST_IMC,
    ST_F_ISR,
    ST_F_ISB_WAIT,
    ST_F_ISB,
    ST_F_ARK,
    ST_DONE
  } ctrl_state_t;

  function automatic logic state_is_busy(input ctrl_state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// 4-bit round down counter with load, decrement and an is-one flag; it holds at 1.
module aes_round_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       is_one_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q > 4'd1)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign is_one_o = (cnt_q == 4'd1);

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Moore sequencer for one AES-128 inverse cipher per start request.
// Define AES_CTRL_SBOX_WAIT_EN to give each InvSubBytes step a one-cycle wait for a registered S-box.
module aes_decrypt_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       key_ready,
  output logic [2:0] msg_sel,
  output logic       ld_state,
  output logic [3:0] rk_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] RK_LAST = 4'(NUM_ROUNDS);
  localparam logic [3:0] RC_INIT = 4'(NUM_ROUNDS - 1);

`ifdef AES_CTRL_SBOX_WAIT_EN
  localparam ctrl_state_t ISB_ENTRY   = ST_ISB_WAIT;
  localparam ctrl_state_t F_ISB_ENTRY = ST_F_ISB_WAIT;
`else
  localparam ctrl_state_t ISB_ENTRY   = ST_ISB;
  localparam ctrl_state_t F_ISB_ENTRY = ST_F_ISB;
`endif

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  msg_sel_t    sel;
  logic        cnt_load;
  logic        cnt_dec;
  logic [3:0]  cnt;
  logic        cnt_is_one;

  aes_round_counter u_round_counter (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (cnt_load),
    .load_val_i (RC_INIT),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .is_one_o   (cnt_is_one)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE:       if (start) state_d = ST_LOAD;
      ST_LOAD:       state_d = ST_KEY_WAIT;
      ST_KEY_WAIT:   if (key_ready) state_d = ST_ARK0;
      ST_ARK0: begin
        cnt_load = 1'b1;
        state_d  = ST_ISR;
      end
      ST_ISR:        state_d = ISB_ENTRY;
      ST_ISB_WAIT:   state_d = ST_ISB;
      ST_ISB:        state_d = ST_ARK;
      ST_ARK:        state_d = ST_IMC;
      // Last middle round exits to the final round instead of decrementing.
      ST_IMC: begin
        if (cnt_is_one) begin
          state_d = ST_F_ISR;
        end else begin
          cnt_dec = 1'b1;
          state_d = ST_ISR;
        end
      end
      ST_F_ISR:      state_d = F_ISB_ENTRY;
      ST_F_ISB_WAIT: state_d = ST_F_ISB;
      ST_F_ISB:      state_d = ST_F_ARK;
      ST_F_ARK:      state_d = ST_DONE;
      ST_DONE:       if (!start) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel      = SEL_MSG;
    ld_state = 1'b0;
    rk_idx   = cnt;
    case (state_q)
      ST_LOAD:       ld_state = 1'b1;
      ST_ARK0: begin
        sel      = SEL_ARK;
        rk_idx   = RK_LAST;
        ld_state = 1'b1;
      end
      ST_ISR, ST_F_ISR: begin
        sel      = SEL_ISR;
        ld_state = 1'b1;
      end
      ST_ISB_WAIT, ST_F_ISB_WAIT: sel = SEL_ISB;
      ST_ISB, ST_F_ISB: begin
        sel      = SEL_ISB;
        ld_state = 1'b1;
      end
      ST_ARK: begin
        sel      = SEL_ARK;
        ld_state = 1'b1;
      end
      ST_IMC: begin
        sel      = SEL_IMC;
        ld_state = 1'b1;
      end
      ST_F_ARK: begin
        sel      = SEL_ARK;
        rk_idx   = '0;
        ld_state = 1'b1;
      end
      default: ;
    endcase
  end

  assign msg_sel = sel;
  assign busy    = state_is_busy(state_q);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Scoreboard bench for aes_decrypt_ctrl: a plan of expected busy-cycle outputs is queued per run
// and a negedge monitor checks every busy cycle and every done arrival against it.
module tb_aes_decrypt_ctrl;

  localparam int NR = 10;
`ifdef AES_CTRL_SBOX_WAIT_EN
  localparam bit SBOX_WAIT = 1'b1;
`else
  localparam bit SBOX_WAIT = 1'b0;
`endif

  typedef struct {
    bit         ld;
    bit         chk_sel;
    logic [2:0] sel;
    bit         chk_rk;
    logic [3:0] rk;
  } step_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       key_ready = 1'b0;
  logic [2:0] msg_sel;
  logic       ld_state;
  logic [3:0] rk_idx;
  logic       busy;
  logic       done;

  step_t plan[$];
  step_t exp_q[$];
  int    done_q[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    ld_cnt = 0;
  bit    done_prev = 1'b0;

  aes_decrypt_ctrl #(.NUM_ROUNDS(NR)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .key_ready (key_ready),
    .msg_sel   (msg_sel),
    .ld_state  (ld_state),
    .rk_idx    (rk_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic step_t mk(bit ld, bit cs, logic [2:0] sel, bit cr, logic [3:0] rk);
    step_t s;
    s.ld = ld; s.chk_sel = cs; s.sel = sel; s.chk_rk = cr; s.rk = rk;
    return s;
  endfunction

  // Reference: ordered list of the busy cycles of one inverse cipher with kw low key_ready samples.
  task automatic build_plan(input int kw);
    plan.delete();
    plan.push_back(mk(1, 1, 3'b100, 0, 4'd0));
    for (int i = 0; i <= kw; i++) plan.push_back(mk(0, 0, 3'b000, 0, 4'd0));
    plan.push_back(mk(1, 1, 3'b000, 1, 4'(NR)));
    for (int r = NR - 1; r >= 1; r--) begin
      plan.push_back(mk(1, 1, 3'b001, 0, 4'd0));
      if (SBOX_WAIT) plan.push_back(mk(0, 1, 3'b011, 0, 4'd0));
      plan.push_back(mk(1, 1, 3'b011, 0, 4'd0));
      plan.push_back(mk(1, 1, 3'b000, 1, 4'(r)));
      plan.push_back(mk(1, 1, 3'b010, 0, 4'd0));
    end
    plan.push_back(mk(1, 1, 3'b001, 0, 4'd0));
    if (SBOX_WAIT) plan.push_back(mk(0, 1, 3'b011, 0, 4'd0));
    plan.push_back(mk(1, 1, 3'b011, 0, 4'd0));
    plan.push_back(mk(1, 1, 3'b000, 1, 4'd0));
  endtask

  always @(negedge Clk) begin
    step_t e;
    if (busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_busy", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.ld && e.sel == 3'b100) ld_cnt = 0;
        chk("ld_state", 32'(ld_state), 32'(e.ld));
        if (e.chk_sel) chk("msg_sel", 32'(msg_sel), 32'(e.sel));
        if (e.chk_rk) chk("rk_idx", 32'(rk_idx), 32'(e.rk));
      end
      if (ld_state === 1'b1) ld_cnt++;
      chk("done_while_busy", 32'(done), 32'd0);
    end
    if (done === 1'b1 && !done_prev) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        chk("loads_per_run", 32'(ld_cnt), 32'd41);
        chk("steps_left_at_done", 32'(exp_q.size()), 32'd0);
      end
    end
    done_prev = (done === 1'b1);
  end

  task automatic check_idle(input string name);
    chk({name, "_msg_sel"}, 32'(msg_sel), 32'd4);
    chk({name, "_ld"}, 32'(ld_state), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  // One start request; abort_rk >= 0 asserts Reset while the ARK step of that round is showing.
  task automatic run(input int kw, input bit hold, input bit jit, input int abort_rk, input bit rel_reset);
    int idx;
    int n;
    build_plan(kw);
    idx = -1;
    @(negedge Clk);
    if (abort_rk >= 0) begin
      for (int i = 0; i < plan.size(); i++)
        if (idx < 0 && plan[i].chk_rk && plan[i].rk == 4'(abort_rk)) idx = i;
      for (int i = 0; i <= idx; i++) exp_q.push_back(plan[i]);
    end else begin
      foreach (plan[i]) exp_q.push_back(plan[i]);
      done_q.push_back(cyc + 1 + plan.size());
    end
    start = 1'b1;
    key_ready = (kw == 0);
    if (rel_reset) Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    start = hold;
    repeat (kw + 1) @(posedge Clk);
    @(negedge Clk);
    key_ready = 1'b1;
    if (abort_rk >= 0) begin
      repeat (idx - kw - 1) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check_idle("after_reset");
      chk("after_reset_rk", 32'(rk_idx), 32'd0);
      Reset = 1'b0;
      start = 1'b0;
      return;
    end
    n = 0;
    while (n < 400) begin
      @(negedge Clk);
      n++;
      if (done === 1'b1) break;
      if (jit) key_ready = 1'($urandom_range(0, 1));
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge Clk);
        chk("done_hold", 32'(done), 32'd1);
        chk("hold_no_restart", 32'(busy), 32'd0);
      end
      start = 1'b0;
    end
    @(negedge Clk);
    check_idle("done_to_idle");
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b1;
    key_ready = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      check_idle("reset");
      chk("reset_rk", 32'(rk_idx), 32'd0);
    end
    run(0, 1'b0, 1'b0, -1, 1'b1);
    run(5, 1'b0, 1'b0, -1, 1'b0);
    run(0, 1'b0, 1'b0, 5, 1'b0);
    run(0, 1'b0, 1'b1, -1, 1'b0);
    run(0, 1'b1, 1'b0, -1, 1'b0);
    run(2, 1'b0, 1'b1, -1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      int kw;
      int ab;
      kw = int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
      run(kw, 1'($urandom_range(0, 1)), 1'b1, ab, 1'b0);
    end
    repeat (3) @(negedge Clk);
    chk("steps_left_at_end", 32'(exp_q.size()), 32'd0);
    chk("dones_left_at_end", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_decrypt_ctrl.md
Name: aes_decrypt_ctrl

Overview:
- Sequencing controller for the AES-128 decryption datapath. It sits directly upstream of the 128-bit state storage register and its step multiplexer.
- Per cycle it drives the step select code, the state load enable and the round-key index consumed by the key-schedule/AddRoundKey path.
- It runs one full inverse cipher per start request and then reports done.

Parameters:
NUM_ROUNDS, 10, number of AES rounds (AES-128); round-key index range 0..NUM_ROUNDS

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high; one clock; takes effect on the rising edge where sampled high
start  input  1  level request; sampled only in IDLE and DONE
key_ready  input  1  key schedule has all NUM_ROUNDS+1 round keys valid
msg_sel  output  3  step select to state storage: 000 AddRoundKey, 001 InvShiftRows, 010 InvMixColumns, 011 InvSubBytes, 100 load message
ld_state  output  1  load enable for all four 32-bit state words
rk_idx  output  4  round-key index for AddRoundKey
busy  output  1  high in every state except IDLE and DONE
done  output  1  high only in DONE

Behaviour:
- Moore machine: outputs are decoded from registered state and the round counter only.
- States and sequence: IDLE -> LOAD -> KEY_WAIT -> ARK0 -> {ISR, ISB, ARK, IMC} repeated for r = NUM_ROUNDS-1 down to 1 -> F_ISR -> F_ISB -> F_ARK -> DONE.
- Reset outputs: state IDLE, msg_sel 100, ld_state 0, rk_idx 0, busy 0, done 0, round counter 0.
- IDLE: msg_sel 100, ld_state 0. start=1 -> LOAD.
- LOAD: msg_sel 100, ld_state 1 (captures ciphertext). Next state is KEY_WAIT.
- KEY_WAIT: ld_state 0. Stays until key_ready=1, then -> ARK0. Minimum 1 cycle.
- ARK0: msg_sel 000, rk_idx NUM_ROUNDS, ld 1. Loads round counter with NUM_ROUNDS-1.
- ISR: msg_sel 001, ld 1.
- ISB: msg_sel 011, ld 1.
- ARK: msg_sel 000, rk_idx r, ld 1.
- IMC: msg_sel 010, ld 1. If r==1 -> F_ISR; else decrement r and -> ISR.
- F_ISR and F_ISB: as ISR and ISB.
- F_ARK: msg_sel 000, rk_idx 0, ld 1.
- rk_idx outside ARK states equals the current round counter value.
- DONE: ld 0, msg_sel 100, done 1. Held while start=1; start=0 -> IDLE. No automatic restart while start stays high.
- Latency: start first sampled high in IDLE at edge t, with key_ready already high. LOAD at cycle t+1, ARK0 at t+3, DONE at t+43. Exactly 41 cycles with ld_state=1 per run.
- start dropping mid-run is ignored; the run completes.
- key_ready dropping after KEY_WAIT is ignored.
- Reset mid-run: IDLE on the next edge, ld_state 0 from that edge.
- Round counter is 4 bits and never wraps below 1 inside the loop.

Optional Feature:
- Macro: AES_CTRL_SBOX_WAIT_EN.
- When defined, each ISB and F_ISB state lasts two cycles for a registered (synchronous ROM) S-box. First cycle: msg_sel 011, ld 0. Second cycle: msg_sel 011, ld 1.
- With the macro defined, DONE is reached at t+53.
- Without the macro, ISB takes a single cycle as above.

Decomposition:
- Package aes_ctrl_pkg holds:
  - enum msg_sel_t: SEL_ARK=3'b000, SEL_ISR=3'b001, SEL_IMC=3'b010, SEL_ISB=3'b011, SEL_MSG=3'b100.
  - enum ctrl_state_t.
  - localparam AES_NUM_ROUNDS=10.
- One natural sub-module: aes_round_counter, a 4-bit down counter with load, decrement and is_one flag.

Test Plan:
- Reset with start=1 for 3 cycles -> outputs hold reset values; release Reset -> LOAD on next edge.
- start pulse at t, key_ready=1 -> ld_state high for 41 cycles; msg_sel trace is 100,000,(001,011,000,010)x9,001,011,000; rk_idx at ARK steps is 10,9..1,0; done at t+43.
- key_ready held low 5 cycles after LOAD -> KEY_WAIT lasts 6 cycles with ld 0; run then completes; done shifted by 5 cycles.
- Reset asserted at ARK for r=5 -> IDLE next edge, ld 0; new start runs a full 41-load sequence.
- start held high through DONE for 10 cycles -> done stays 1, no LOAD; start low -> IDLE; start high -> new run.
- With AES_CTRL_SBOX_WAIT_EN defined: same stimulus -> each ISB shows one cycle of 011 with ld 0 before the load; done at t+53.
